// File: rtl/evt_fork_sel_scheduler.sv
// Select-port scheduler for evt_stream_dynamic_fork.
// Maps an event key to a destination mask and issues it through a one-entry stage.
module evt_fork_sel_scheduler #(
  parameter int N_OUP = 2,
  parameter int KEY_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [N_OUP-1:0] sel_o,
  output logic             sel_valid_o,
  input  logic             sel_ready_i,
  input  logic [1:0]       mode_i,
  input  logic [N_OUP-1:0] enable_i,
  input  logic             cfg_we_i,
  input  logic [KEY_W-1:0] cfg_addr_i,
  input  logic [N_OUP-1:0] cfg_mask_i,
  output logic [CNT_W-1:0] drop_cnt_o,
  input  logic             drop_clr_i
);

  localparam int PTR_W = (N_OUP > 1) ? $clog2(N_OUP) : 1;
  localparam int N_ENT = 1 << KEY_W;

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t           state_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_next;
  logic [N_OUP-1:0] route_tbl [N_ENT];
  logic [N_OUP-1:0] rr_mask;
  logic [N_OUP-1:0] mask;
  logic             accept;
  logic             is_rr;
  logic             is_bc;
  int               hi_idx;
  int               lo_idx;
  int               sel_idx;
  logic             hi_hit;

  assign sel_valid_o = (state_q == FULL);
  assign key_ready_o = !sel_valid_o || sel_ready_i;
  assign accept      = key_valid_i && key_ready_o;
  assign is_rr       = (mode_i == 2'd1);
  assign is_bc       = (mode_i == 2'd2);

  // First enabled index at or above the pointer; else wrap to the lowest.
  always_comb begin
    hi_idx = 0;
    lo_idx = 0;
    hi_hit = 1'b0;
    for (int j = N_OUP - 1; j >= 0; j--) begin
      if (enable_i[j]) begin
        lo_idx = j;
        if (j >= int'(rr_ptr_q)) begin
          hi_idx = j;
          hi_hit = 1'b1;
        end
      end
    end
    sel_idx = hi_hit ? hi_idx : lo_idx;
    rr_mask = '0;
    for (int j = 0; j < N_OUP; j++) begin
      if (j == sel_idx) rr_mask[j] = |enable_i;
    end
    rr_next = PTR_W'((sel_idx + 1) % N_OUP);
  end

  always_comb begin
    mask = '0;
    unique case (1'b1)
      is_rr:   mask = rr_mask;
      is_bc:   mask = enable_i;
      default: mask = route_tbl[key_i] & enable_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      sel_o   <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            sel_o   <= mask;
          end
        end
        FULL: begin
          if (accept) begin
            sel_o <= mask;
          end else if (sel_ready_i) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (accept && is_rr && |rr_mask) begin
      rr_ptr_q <= rr_next;
    end
  end

  // Lookup reads the pre-write contents, so a colliding write is seen next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ENT; i++) route_tbl[i] <= '1;
    end else if (cfg_we_i) begin
      route_tbl[cfg_addr_i] <= cfg_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_o <= '0;
    end else if (drop_clr_i) begin
      drop_cnt_o <= '0;
    end else if (accept && mask == '0 && drop_cnt_o != '1) begin
      drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

endmodule
